regfile_scoreboard: RTL and testbench

- Hazard scoreboard for the in-order RISC-V pipeline's architectural register file.
- Tracks pending register writes with one counter per register:
  - incremented when the decode stage issues a register-writing instruction;
  - decremented when writeback retires that write, or when the issued instruction is squashed by a branch redirect.
- Drives the decode-stage stall and exposes busy and occupancy status for the fetch and decode stages and for the bench.

---
 rtl/regfile_scoreboard_if.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 135 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: issue/source request from decode, flush
// and squash from the branch unit, writeback retire, and the scoreboard's
// stall/status responses.
interface regfile_scoreboard_if #(
    parameter int NREGS     = 32,
    parameter int REGNOBITS = 5
);
    logic                 issue_valid;
    logic                 issue_wr_reg;
    logic [REGNOBITS-1:0] issue_rd;
    logic                 rs1_read;
    logic [REGNOBITS-1:0] rs1;
    logic                 rs2_read;
    logic [REGNOBITS-1:0] rs2;
    logic                 flush;
    logic                 squash_valid;
    logic [REGNOBITS-1:0] squash_rd;
    logic                 wb_valid;
    logic [REGNOBITS-1:0] wb_rd;
    logic                 stall;
    logic                 issue_fire;
    logic [NREGS-1:0]     busy_vec;
    logic [3:0]           inflight;
    logic [31:0]          stall_cycles;
    logic                 err_underflow;

    modport master (
        output issue_valid, issue_wr_reg, issue_rd,
        output rs1_read, rs1, rs2_read, rs2,
        output flush, squash_valid, squash_rd, wb_valid, wb_rd,
        input  stall, issue_fire, busy_vec, inflight, stall_cycles, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wr_reg, issue_rd,
        input  rs1_read, rs1, rs2_read, rs2,
        input  flush, squash_valid, squash_rd, wb_valid, wb_rd,
        output stall, issue_fire, busy_vec, inflight, stall_cycles, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard: one pending-write counter per
// architectural register. Issue increments, writeback and squash decrement.
// Produces the decode stall and registered busy/occupancy/error status.
module regfile_scoreboard #(
    parameter int NREGS     = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  sb
);

    localparam int SUMBITS = 16;
    localparam logic [CNTBITS-1:0] CNT_ZERO = {CNTBITS{1'b0}};
    localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
    localparam logic [CNTBITS-1:0] CNT_MAX  = {CNTBITS{1'b1}};
    localparam logic [REGNOBITS-1:0] REG_X0 = {REGNOBITS{1'b0}};

    logic [CNTBITS-1:0] cnt_r      [NREGS];
    logic [CNTBITS-1:0] cnt_nxt_s  [NREGS];
    logic [NREGS-1:0]   busy_r;
    logic [NREGS-1:0]   busy_nxt_s;
    logic [3:0]         inflight_r;
    logic [3:0]         inflight_nxt_s;
    logic [31:0]        stall_cycles_r;
    logic               err_underflow_r;
    logic               uf_s;
    logic [SUMBITS-1:0] sum_s;
    logic               rs1_hz_s;
    logic               rs2_hz_s;
    logic               ovf_s;
    logic               stall_s;
    logic               issue_fire_s;

    // Source operand is busy unless x0, idle, or released by a same-cycle
    // writeback of its last outstanding write (regfile writes on negedge).
    function automatic logic src_busy(
        input logic [REGNOBITS-1:0] idx,
        input logic [CNTBITS-1:0]   cnt,
        input logic                 wb_v,
        input logic [REGNOBITS-1:0] wb_idx
    );
        logic bypass_v;
        bypass_v = (WB_BYPASS != 32'sd0) && (cnt == CNT_ONE) && wb_v && (wb_idx == idx);
        return (idx != REG_X0) && (cnt != CNT_ZERO) && !bypass_v;
    endfunction

    // Decode stall: RAW hazard on either source or a saturated rd counter.
    always_comb begin
        rs1_hz_s = sb.rs1_read && src_busy(sb.rs1, cnt_r[sb.rs1], sb.wb_valid, sb.wb_rd);
        rs2_hz_s = sb.rs2_read && src_busy(sb.rs2, cnt_r[sb.rs2], sb.wb_valid, sb.wb_rd);
        ovf_s    = sb.issue_wr_reg && (sb.issue_rd != REG_X0) && (cnt_r[sb.issue_rd] == CNT_MAX);
        if (sb.issue_valid) begin
            stall_s = rs1_hz_s | rs2_hz_s | ovf_s;
        end else begin
            stall_s = 1'b0;
        end
        issue_fire_s = sb.issue_valid & ~stall_s & ~sb.flush;
    end

    assign sb.stall      = stall_s;
    assign sb.issue_fire = issue_fire_s;

    // Next counter values: net of issue minus writeback minus squash, clamped at zero.
    always_comb begin
        logic               inc_s;
        logic               dec_wb_s;
        logic               dec_sq_s;
        logic [CNTBITS:0]   base_s;
        logic [CNTBITS:0]   dec_s;
        uf_s       = 1'b0;
        sum_s      = {SUMBITS{1'b0}};
        busy_nxt_s = {NREGS{1'b0}};
        inc_s      = 1'b0;
        dec_wb_s   = 1'b0;
        dec_sq_s   = 1'b0;
        base_s     = {(CNTBITS+1){1'b0}};
        dec_s      = {(CNTBITS+1){1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            if (r == 0) begin
                cnt_nxt_s[r] = CNT_ZERO;
            end else begin
                inc_s    = issue_fire_s & sb.issue_wr_reg & (sb.issue_rd == REGNOBITS'(r));
                dec_wb_s = sb.wb_valid & (sb.wb_rd == REGNOBITS'(r));
                dec_sq_s = sb.squash_valid & (sb.squash_rd == REGNOBITS'(r));
                base_s   = {1'b0, cnt_r[r]} + {{CNTBITS{1'b0}}, inc_s};
                dec_s    = {{CNTBITS{1'b0}}, dec_wb_s} + {{CNTBITS{1'b0}}, dec_sq_s};
                if (base_s < dec_s) begin
                    cnt_nxt_s[r] = CNT_ZERO;
                    uf_s         = 1'b1;
                end else begin
                    cnt_nxt_s[r] = CNTBITS'(base_s - dec_s);
                end
            end
            busy_nxt_s[r] = (r != 0) && (cnt_nxt_s[r] != CNT_ZERO);
            sum_s         = sum_s + SUMBITS'(cnt_nxt_s[r]);
        end
        if (sum_s > 16'd15) begin
            inflight_nxt_s = 4'hF;
        end else begin
            inflight_nxt_s = sum_s[3:0];
        end
    end

    // State and registered status; async reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            busy_r          <= {NREGS{1'b0}};
            inflight_r      <= 4'd0;
            stall_cycles_r  <= 32'd0;
            err_underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            busy_r     <= busy_nxt_s;
            inflight_r <= inflight_nxt_s;
            if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            err_underflow_r <= err_underflow_r | uf_s;
        end
    end

    assign sb.busy_vec      = busy_r;
    assign sb.inflight      = inflight_r;
    assign sb.stall_cycles  = stall_cycles_r;
    assign sb.err_underflow = err_underflow_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, all compared against an integer-array reference model.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.NREGS(32), .REGNOBITS(5)) sbif ();

    regfile_scoreboard #(
        .NREGS(32), .REGNOBITS(5), .CNTBITS(2), .WB_BYPASS(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    int          cnt_m [32];
    bit          err_m;
    int unsigned stall_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input bit wr, input int rd,
                         input bit r1r, input int r1, input bit r2r, input int r2,
                         input bit fl, input bit sqv, input int sqrd,
                         input bit wbv, input int wbrd);
        sbif.issue_valid  = iv;
        sbif.issue_wr_reg = wr;
        sbif.issue_rd     = 5'(rd);
        sbif.rs1_read     = r1r;
        sbif.rs1          = 5'(r1);
        sbif.rs2_read     = r2r;
        sbif.rs2          = 5'(r2);
        sbif.flush        = fl;
        sbif.squash_valid = sqv;
        sbif.squash_rd    = 5'(sqrd);
        sbif.wb_valid     = wbv;
        sbif.wb_rd        = 5'(wbrd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference: a source is busy if it has pending writes, unless it is x0
    // or its only pending write retires this very cycle.
    function automatic bit m_busy(int r);
        if (r == 0 || cnt_m[r] == 0) return 1'b0;
        if (cnt_m[r] == 1 && sbif.wb_valid && int'(sbif.wb_rd) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        int rd;
        rd = int'(sbif.issue_rd);
        if (!sbif.issue_valid) return 1'b0;
        return (sbif.rs1_read && m_busy(int'(sbif.rs1))) ||
               (sbif.rs2_read && m_busy(int'(sbif.rs2))) ||
               (sbif.issue_wr_reg && rd != 0 && cnt_m[rd] == 3);
    endfunction

    task automatic check_regs();
        logic [31:0] bv;
        int sum;
        bv  = 32'd0;
        sum = 0;
        for (int r = 0; r < 32; r++) begin
            bv[r] = (r != 0) && (cnt_m[r] != 0);
            sum  += cnt_m[r];
        end
        check_val("busy_vec", sbif.busy_vec, bv);
        check_val("inflight", sbif.inflight, (sum > 15) ? 15 : sum);
        check_val("stall_cycles", sbif.stall_cycles, stall_m);
        check_val("err_underflow", sbif.err_underflow, err_m);
    endtask

    // One clock: check combinational outputs, clock, update model, check registers.
    task automatic step();
        bit st, fire, wr, wbv, sqv;
        int rd, wbrd, sqrd;
        #1;
        st   = m_stall();
        fire = sbif.issue_valid && !st && !sbif.flush;
        check_val("stall", sbif.stall, st);
        check_val("issue_fire", sbif.issue_fire, fire);
        wr = sbif.issue_wr_reg; rd = int'(sbif.issue_rd);
        wbv = sbif.wb_valid; wbrd = int'(sbif.wb_rd);
        sqv = sbif.squash_valid; sqrd = int'(sbif.squash_rd);
        @(posedge clk);
        if (st) stall_m++;
        if (fire && wr && rd != 0) cnt_m[rd]++;
        if (wbv && wbrd != 0) begin
            if (cnt_m[wbrd] > 0) cnt_m[wbrd]--; else err_m = 1'b1;
        end
        if (sqv && sqrd != 0) begin
            if (cnt_m[sqrd] > 0) cnt_m[sqrd]--; else err_m = 1'b1;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m   = 1'b0;
        stall_m = 0;
    endtask

    // Assert reset between edges and confirm every registered output clears at once.
    task automatic do_reset();
        idle();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_val("rst_busy_vec", sbif.busy_vec, 0);
        check_val("rst_inflight", sbif.inflight, 0);
        check_val("rst_stall_cycles", sbif.stall_cycles, 0);
        check_val("rst_err", sbif.err_underflow, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int iv, wr, rd, r1r, r1, r2r, r2, fl, sqv, sqrd, wbv, wbrd;
        reset = 1'b1;
        idle();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_regs();

        // RAW hazard on x5 released by a bypassed writeback
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 6, 1, 5, 1, 1, 0, 0, 0, 0, 0); step(); step();
        drive(1, 1, 6, 1, 5, 1, 1, 0, 0, 0, 1, 5); step();
        check_val("t1_busy5", sbif.busy_vec[5], 0);
        check_val("t1_busy6", sbif.busy_vec[6], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6); step();

        // Counter saturation on x7
        repeat (3) begin drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
        check_val("t2_inflight3", sbif.inflight, 3);
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 7); step();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("t2_inflight_refill", sbif.inflight, 3);
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step(); end

        // Flush blocks issue; squash releases an issued writer
        drive(1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();
        check_val("t3_flush_busy9", sbif.busy_vec[9], 0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
        check_val("t3_squash_busy9", sbif.busy_vec[9], 0);

        // Simultaneous issue and writeback on x4
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 4); step();
        check_val("t4_busy4", sbif.busy_vec[4], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4); step();

        // Same-cycle wb and squash on x8 holding two writes
        repeat (2) begin drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 8); step();
        check_val("t4_busy8", sbif.busy_vec[8], 0);

        // Underflow: x0 ignored, x12 flags and sticks
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        check_val("t5_x0_noerr", sbif.err_underflow, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12); step();
        check_val("t5_err", sbif.err_underflow, 1);
        idle(); step();
        check_val("t5_err_sticky", sbif.err_underflow, 1);
        do_reset();

        // Stall counting and x0 writer
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        repeat (5) begin drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0); step(); end
        check_val("t6_stall_cycles", sbif.stall_cycles, 5);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("t6_x0_busy", sbif.busy_vec[0], 0);
        check_val("t6_x0_inflight", sbif.inflight, 1);

        // inflight saturation: 18 outstanding writes across x1..x6
        for (int r = 1; r <= 6; r++) begin
            repeat (3) begin drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
        end
        check_val("t7_inflight_sat", sbif.inflight, 15);
        do_reset();

        // Random traffic on a small register window
        for (int c = 0; c < 800; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            wr   = ($urandom_range(0, 3) != 0);
            rd   = $urandom_range(0, 7);
            r1r  = $urandom_range(0, 1);
            r1   = $urandom_range(0, 7);
            r2r  = $urandom_range(0, 1);
            r2   = $urandom_range(0, 7);
            fl   = ($urandom_range(0, 9) == 0);
            wbrd = $urandom_range(0, 7);
            wbv  = ($urandom_range(0, 1) == 0);
            if (cnt_m[wbrd] == 0 && $urandom_range(0, 49) != 0) wbv = 0;
            sqrd = $urandom_range(0, 7);
            sqv  = ($urandom_range(0, 5) == 0);
            if (cnt_m[sqrd] == 0 && $urandom_range(0, 49) != 0) sqv = 0;
            drive(iv[0], wr[0], rd, r1r[0], r1, r2r[0], r2, fl[0], sqv[0], sqrd, wbv[0], wbrd);
            step();
            if (c == 400) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
